// File: rtl/risc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : risc_pkg
// Description : Definitions shared by the RISC core and its helper blocks.
//               Holds the memory geometry defaults and the state encoding
//               of the post-halt memory dump reader.
//               No ports (package).
// Revision    : 1.0 - initial release
// ============================================================================
package risc_pkg;

    // Memory geometry of the core; helper blocks default to these.
    localparam int c_AWIDTH_DEFAULT = 5;
    localparam int c_DWIDTH_DEFAULT = 8;

    // Dump reader states, explicit 2-bit encoding.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_READ    = 2'd1,
        ST_PRESENT = 2'd2,
        ST_DONE    = 2'd3
    } dump_state_e;

endpackage : risc_pkg
`default_nettype wire

// File: rtl/Counter.sv
`default_nettype none
// ============================================================================
// Module      : Counter
// Description : Loadable up-counter, wraps modulo 2^COUNTER_WIDTH.
//               Load has priority over enable.
// Ports       : clk     - clock, rising edge
//               rst     - synchronous active-high reset (count -> 0)
//               load    - load cnt_in on the next edge
//               enable  - increment on the next edge
//               cnt_in  - value to load
//               cnt_out - current count (registered)
// Revision    : 1.0 - initial release
// ============================================================================
module Counter #(
    parameter int COUNTER_WIDTH = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load,
    input  logic                     enable,
    input  logic [COUNTER_WIDTH-1:0] cnt_in,
    output logic [COUNTER_WIDTH-1:0] cnt_out
);

    logic [COUNTER_WIDTH-1:0] count_q;
    logic [COUNTER_WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = cnt_in;
        end else if (enable) begin
            count_d = count_q + COUNTER_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign cnt_out = count_q;

endmodule : Counter
`default_nettype wire

// File: rtl/mem_dump_reader.sv
`default_nettype none
// ============================================================================
// Module      : mem_dump_reader
// Description : Post-halt memory readout engine. On a rising edge of halt
//               it takes the memory read port, reads a window of
//               dump_count words starting at dump_base (wrapping at the top
//               of memory) and presents each word with its address on a
//               valid/ready stream. dump_done is raised after the last
//               accepted word and held until halt falls.
// Ports       : clk, rst         - clock, synchronous active-high reset
//               halt             - CPU halt flag
//               dump_base        - first window address (sampled at trigger)
//               dump_count       - window length, 0 = 2^AWIDTH
//               mem_own          - this block owns the memory read port
//               mem_rd/mem_addr  - memory read strobe and address
//               mem_data         - combinational memory read data
//               dump_valid/ready - output stream handshake
//               dump_addr/data   - presented word and its address
//               dump_done        - window completely transferred
// Revision    : 1.0 - initial release
// ============================================================================
module mem_dump_reader
    import risc_pkg::*;
#(
    parameter int AWIDTH = c_AWIDTH_DEFAULT,
    parameter int DWIDTH = c_DWIDTH_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              halt,
    input  logic [AWIDTH-1:0] dump_base,
    input  logic [AWIDTH-1:0] dump_count,
    output logic              mem_own,
    output logic              mem_rd,
    output logic [AWIDTH-1:0] mem_addr,
    input  logic [DWIDTH-1:0] mem_data,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [AWIDTH-1:0] dump_addr,
    output logic [DWIDTH-1:0] dump_data,
    output logic              dump_done
);

    localparam logic [AWIDTH:0] c_REM_ONE  = (AWIDTH+1)'(1);
    localparam logic [AWIDTH:0] c_REM_FULL = {1'b1, {AWIDTH{1'b0}}};

    dump_state_e       state_q,      state_d;
    logic              halt_q,       halt_d;
    logic              arm_q,        arm_d;
    logic [AWIDTH:0]   remaining_q,  remaining_d;
    logic              mem_own_q,    mem_own_d;
    logic              mem_rd_q,     mem_rd_d;
    logic              dump_valid_q, dump_valid_d;
    logic [AWIDTH-1:0] dump_addr_q,  dump_addr_d;
    logic [DWIDTH-1:0] dump_data_q,  dump_data_d;
    logic              dump_done_q,  dump_done_d;

    logic              w_trigger;
    logic              w_handshake;
    logic              w_cnt_enable;
    logic [AWIDTH-1:0] w_cur_addr;

    // A halt that is already high when reset releases must not start a dump;
    // arm_q records that halt has been seen low since reset, so only a true
    // low-to-high transition afterwards counts as a trigger.
    assign w_trigger    = halt && !halt_q && arm_q;
    assign w_handshake  = (state_q == ST_PRESENT) && dump_valid_q && dump_ready;
    assign w_cnt_enable = w_handshake && (remaining_q != c_REM_ONE);

    Counter #(
        .COUNTER_WIDTH (AWIDTH)
    ) u_addr_cnt (
        .clk     (clk),
        .rst     (rst),
        .load    (w_trigger && (state_q == ST_IDLE)),
        .enable  (w_cnt_enable),
        .cnt_in  (dump_base),
        .cnt_out (w_cur_addr)
    );

    always_comb begin
        state_d      = state_q;
        halt_d       = halt;
        arm_d        = arm_q || !halt;
        remaining_d  = remaining_q;
        mem_own_d    = mem_own_q;
        mem_rd_d     = mem_rd_q;
        dump_valid_d = dump_valid_q;
        dump_addr_d  = dump_addr_q;
        dump_data_d  = dump_data_q;
        dump_done_d  = dump_done_q;

        case (state_q)
            ST_IDLE: begin
                if (w_trigger) begin
                    remaining_d = (dump_count == '0) ? c_REM_FULL
                                                     : {1'b0, dump_count};
                    mem_own_d   = 1'b1;
                    mem_rd_d    = 1'b1;
                    state_d     = ST_READ;
                end
            end

            ST_READ: begin
                if (!halt) begin
                    mem_own_d    = 1'b0;
                    mem_rd_d     = 1'b0;
                    dump_valid_d = 1'b0;
                    state_d      = ST_IDLE;
                end else begin
                    dump_data_d  = mem_data;
                    dump_addr_d  = w_cur_addr;
                    dump_valid_d = 1'b1;
                    mem_rd_d     = 1'b0;
                    state_d      = ST_PRESENT;
                end
            end

            ST_PRESENT: begin
                if (!halt) begin
                    mem_own_d    = 1'b0;
                    mem_rd_d     = 1'b0;
                    dump_valid_d = 1'b0;
                    state_d      = ST_IDLE;
                end else if (w_handshake) begin
                    dump_valid_d = 1'b0;
                    if (remaining_q == c_REM_ONE) begin
                        mem_own_d   = 1'b0;
                        dump_done_d = 1'b1;
                        state_d     = ST_DONE;
                    end else begin
                        remaining_d = remaining_q - c_REM_ONE;
                        mem_rd_d    = 1'b1;
                        state_d     = ST_READ;
                    end
                end
            end

            ST_DONE: begin
                if (!halt) begin
                    dump_done_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end

            default: begin
                mem_own_d    = 1'b0;
                mem_rd_d     = 1'b0;
                dump_valid_d = 1'b0;
                dump_done_d  = 1'b0;
                state_d      = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            halt_q       <= 1'b0;
            arm_q        <= 1'b0;
            remaining_q  <= '0;
            mem_own_q    <= 1'b0;
            mem_rd_q     <= 1'b0;
            dump_valid_q <= 1'b0;
            dump_addr_q  <= '0;
            dump_data_q  <= '0;
            dump_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            halt_q       <= halt_d;
            arm_q        <= arm_d;
            remaining_q  <= remaining_d;
            mem_own_q    <= mem_own_d;
            mem_rd_q     <= mem_rd_d;
            dump_valid_q <= dump_valid_d;
            dump_addr_q  <= dump_addr_d;
            dump_data_q  <= dump_data_d;
            dump_done_q  <= dump_done_d;
        end
    end

    // The address counter is loaded at trigger, so it already holds the
    // window address during READ; the address is forced to 0 whenever the
    // port is not owned so the top mux never sees a stale value.
    assign mem_own    = mem_own_q;
    assign mem_rd     = mem_rd_q;
    assign mem_addr   = mem_own_q ? w_cur_addr : '0;
    assign dump_valid = dump_valid_q;
    assign dump_addr  = dump_addr_q;
    assign dump_data  = dump_data_q;
    assign dump_done  = dump_done_q;

endmodule : mem_dump_reader
`default_nettype wire

// File: tb/tb_mem_dump_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_dump_reader
// Description : Self-checking bench for mem_dump_reader. A memory array
//               answers the read port; expected (addr, data) pairs are
//               queued when a dump is started and popped on each handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_dump_reader;

    logic       clk;
    logic       rst;
    logic       halt;
    logic [4:0] dump_base;
    logic [4:0] dump_count;
    logic       mem_own;
    logic       mem_rd;
    logic [4:0] mem_addr;
    logic [7:0] mem_data;
    logic       dump_valid;
    logic       dump_ready;
    logic [4:0] dump_addr;
    logic [7:0] dump_data;
    logic       dump_done;

    logic [7:0] mem [0:31];

    typedef struct packed {
        logic [4:0] a;
        logic [7:0] d;
    } word_t;

    word_t sbq[$];
    int    total;
    int    bad;
    int    accepted;
    int    rd_pulses;

    mem_dump_reader #(
        .AWIDTH (5),
        .DWIDTH (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .halt       (halt),
        .dump_base  (dump_base),
        .dump_count (dump_count),
        .mem_own    (mem_own),
        .mem_rd     (mem_rd),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .dump_valid (dump_valid),
        .dump_ready (dump_ready),
        .dump_addr  (dump_addr),
        .dump_data  (dump_data),
        .dump_done  (dump_done)
    );

    assign mem_data = mem[mem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Queue the expected words of a window, wrapping at the top of memory.
    task automatic push_window(input logic [4:0] base, input int count);
        word_t      w;
        logic [4:0] a;
        for (int i = 0; i < count; i++) begin
            a   = base + 5'(i);
            w.a = a;
            w.d = mem[a];
            sbq.push_back(w);
        end
    endtask

    // Compare the word about to be accepted at the coming edge, then advance
    // one cycle and sample 1 time unit after the edge.
    task automatic tick();
        word_t w;
        if (dump_valid && dump_ready) begin
            accepted++;
            if (sbq.size() == 0) begin
                chk("unexpected_word", 32'd1, 32'd0);
            end else begin
                w = sbq.pop_front();
                chk("word_addr", 32'(dump_addr), 32'(w.a));
                chk("word_data", 32'(dump_data), 32'(w.d));
            end
        end
        @(posedge clk);
        #1;
        if (mem_rd) rd_pulses++;
    endtask

    task automatic run_until_done(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (dump_done) break;
            tick();
        end
        chk({tag, "_done"}, 32'(dump_done), 32'd1);
        chk({tag, "_own_off"}, 32'(mem_own), 32'd0);
        chk({tag, "_queue_empty"}, 32'(sbq.size()), 32'd0);
        halt = 1'b0;
        tick();
        chk({tag, "_done_clear"}, 32'(dump_done), 32'd0);
        tick();
    endtask

    initial begin
        logic [4:0] saved_addr;
        logic [7:0] saved_data;
        int         rd_before;
        int         acc_before;

        total      = 0;
        bad        = 0;
        accepted   = 0;
        rd_pulses  = 0;
        rst        = 1'b1;
        halt       = 1'b0;
        dump_base  = '0;
        dump_count = '0;
        dump_ready = 1'b1;
        for (int i = 0; i < 32; i++) mem[i] = 8'(i * 13 + 5);
        mem[0] = 8'hA1;
        mem[1] = 8'hB2;
        mem[2] = 8'hC3;
        mem[3] = 8'hD4;

        // Reset state
        tick();
        tick();
        rst = 1'b0;
        chk("rst_valid", 32'(dump_valid), 32'd0);
        chk("rst_own", 32'(mem_own), 32'd0);
        chk("rst_rd", 32'(mem_rd), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_daddr", 32'(dump_addr), 32'd0);
        chk("rst_ddata", 32'(dump_data), 32'd0);
        chk("rst_done", 32'(dump_done), 32'd0);
        tick();

        // Base 0, count 4, ready held high: exact cycle timing
        dump_base  = 5'd0;
        dump_count = 5'd4;
        push_window(5'd0, 4);
        halt = 1'b1;
        tick();
        chk("t1_read_valid", 32'(dump_valid), 32'd0);
        chk("t1_read_rd", 32'(mem_rd), 32'd1);
        chk("t1_read_own", 32'(mem_own), 32'd1);
        chk("t1_read_addr", 32'(mem_addr), 32'd0);
        for (int k = 2; k <= 9; k++) begin
            tick();
            chk($sformatf("t1_valid_T%0d", k), 32'(dump_valid),
                ((k % 2) == 0 && k <= 8) ? 32'd1 : 32'd0);
        end
        chk("t1_done_T9", 32'(dump_done), 32'd1);
        chk("t1_own_T9", 32'(mem_own), 32'd0);
        run_until_done("t1", 4);

        // Window wrapping across the top of memory
        dump_base  = 5'd30;
        dump_count = 5'd4;
        push_window(5'd30, 4);
        halt = 1'b1;
        run_until_done("wrap", 40);

        // Count 0 means the whole memory
        dump_base  = 5'd0;
        dump_count = 5'd0;
        acc_before = accepted;
        push_window(5'd0, 32);
        halt = 1'b1;
        run_until_done("full", 200);
        chk("full_words", 32'(accepted - acc_before), 32'd32);

        // Back-pressure on the second word
        dump_base  = 5'd4;
        dump_count = 5'd4;
        push_window(5'd4, 4);
        halt = 1'b1;
        tick();
        tick();
        tick();
        dump_ready = 1'b0;
        tick();
        chk("bp_valid", 32'(dump_valid), 32'd1);
        saved_addr = dump_addr;
        saved_data = dump_data;
        rd_before  = rd_pulses;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("bp_hold_valid", 32'(dump_valid), 32'd1);
            chk("bp_hold_addr", 32'(dump_addr), 32'(saved_addr));
            chk("bp_hold_data", 32'(dump_data), 32'(saved_data));
        end
        chk("bp_no_rd", 32'(rd_pulses - rd_before), 32'd0);
        dump_ready = 1'b1;
        tick();
        chk("bp_after_accept_valid", 32'(dump_valid), 32'd0);
        chk("bp_after_accept_rd", 32'(mem_rd), 32'd1);
        tick();
        chk("bp_next_valid", 32'(dump_valid), 32'd1);
        chk("bp_next_addr", 32'(dump_addr), 32'd6);
        run_until_done("bp", 20);

        // Abort while the first word is presented, then restart
        dump_base  = 5'd8;
        dump_count = 5'd4;
        dump_ready = 1'b0;
        halt       = 1'b1;
        tick();
        tick();
        chk("ab_present", 32'(dump_valid), 32'd1);
        halt = 1'b0;
        tick();
        chk("ab_valid", 32'(dump_valid), 32'd0);
        chk("ab_own", 32'(mem_own), 32'd0);
        chk("ab_done", 32'(dump_done), 32'd0);
        tick();
        dump_ready = 1'b1;
        push_window(5'd8, 4);
        halt = 1'b1;
        run_until_done("ab_restart", 30);

        // Reset in the middle of READ, halt held high afterwards
        dump_base  = 5'd2;
        dump_count = 5'd3;
        halt       = 1'b1;
        tick();
        chk("rs_read_rd", 32'(mem_rd), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rs_own", 32'(mem_own), 32'd0);
        chk("rs_rd", 32'(mem_rd), 32'd0);
        chk("rs_valid", 32'(dump_valid), 32'd0);
        chk("rs_daddr", 32'(dump_addr), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rs_no_retrigger", 32'({mem_own, mem_rd, dump_valid}), 32'd0);
        end
        halt = 1'b0;
        tick();
        push_window(5'd2, 3);
        halt = 1'b1;
        run_until_done("rs_restart", 30);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_mem_dump_reader
`default_nettype wire
